// File: rtl/plru_set_ctrl.sv
// Tree-PLRU replacement controller for an 8-way cache: one 7-bit word per set, serialised hit/victim access.
// Optional macro PLRU_SET_CTRL_STATS_EN adds saturating hit/victim completion counters.
module plru_set_ctrl #(
  parameter int NUM_SETS = 64
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        hit_valid_i,
  output logic                        hit_ready_o,
  input  logic [$clog2(NUM_SETS)-1:0] hit_set_i,
  input  logic [7:0]                  hit_way_i,
  input  logic                        vic_valid_i,
  output logic                        vic_ready_o,
  input  logic [$clog2(NUM_SETS)-1:0] vic_set_i,
  output logic                        vic_resp_valid_o,
  output logic [2:0]                  vic_resp_way_o,
  input  logic                        vic_resp_ready_i,
  output logic                        busy_o
`ifdef PLRU_SET_CTRL_STATS_EN
  ,
  output logic [15:0]                 stat_hit_cnt_o,
  output logic [15:0]                 stat_vic_cnt_o
`endif
);

  localparam int SET_W = $clog2(NUM_SETS);
  localparam logic RR_HIT = 1'b0;
  localparam logic RR_VIC = 1'b1;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RD = 2'd1, ST_WR = 2'd2} state_e;

  function automatic logic [2:0] plru_victim(input logic [6:0] w);
    logic [2:0] v;
    if (w[6]) begin
      if (w[5]) v = w[3] ? 3'd7 : 3'd6;
      else      v = w[2] ? 3'd5 : 3'd4;
    end else begin
      if (w[4]) v = w[1] ? 3'd3 : 3'd2;
      else      v = w[0] ? 3'd1 : 3'd0;
    end
    return v;
  endfunction

  // A node flips when the access touches the side it currently marks as LRU.
  function automatic logic [6:0] plru_update(input logic [6:0] w, input logic [7:0] m);
    logic [6:0] f;
    f[6] = w[6] ? |m[7:4] : |m[3:0];
    f[5] = w[5] ? |m[7:6] : |m[5:4];
    f[4] = w[4] ? |m[3:2] : |m[1:0];
    f[3] = w[3] ? m[7] : m[6];
    f[2] = w[2] ? m[5] : m[4];
    f[1] = w[1] ? m[3] : m[2];
    f[0] = w[0] ? m[1] : m[0];
    return w ^ f;
  endfunction

  state_e           state_q, state_d;
  logic [SET_W-1:0] set_q;
  logic [7:0]       map_q;
  logic             vic_q;
  logic [6:0]       word_q;
  logic             rr_q;
  logic             resp_valid_q;
  logic [2:0]       resp_way_q;
  logic             wr_done_q;
  logic [6:0]       words_q [NUM_SETS];

  logic             grant_hit, grant_vic, wr_en, leave_wr;
  logic [6:0]       rd_word, new_word;
  logic [2:0]       rd_victim;

  assign rd_word   = words_q[set_q];
  assign rd_victim = plru_victim(rd_word);
  assign new_word  = plru_update(word_q, map_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_hit || grant_vic) state_d = ST_RD;
        else                        state_d = ST_IDLE;
      end
      ST_RD:   state_d = ST_WR;
      ST_WR: begin
        if (!vic_q || vic_resp_ready_i) state_d = ST_IDLE;
        else                            state_d = ST_WR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    hit_ready_o = 1'b0;
    vic_ready_o = 1'b0;
    wr_en       = 1'b0;
    leave_wr    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        hit_ready_o = !vic_valid_i || (rr_q == RR_HIT);
        vic_ready_o = !hit_valid_i || (rr_q == RR_VIC);
      end
      ST_WR: begin
        wr_en    = !wr_done_q;
        leave_wr = !vic_q || vic_resp_ready_i;
      end
      default: begin
        hit_ready_o = 1'b0;
        vic_ready_o = 1'b0;
      end
    endcase
  end

  assign grant_hit        = hit_valid_i && hit_ready_o;
  assign grant_vic        = vic_valid_i && vic_ready_o;
  assign busy_o           = (state_q != ST_IDLE);
  assign vic_resp_valid_o = resp_valid_q;
  assign vic_resp_way_o   = resp_way_q;

  // Request latch, word read, victim selection and response handshake.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      set_q        <= '0;
      map_q        <= 8'h00;
      vic_q        <= 1'b0;
      word_q       <= 7'b0;
      rr_q         <= RR_HIT;
      resp_valid_q <= 1'b0;
      resp_way_q   <= 3'd0;
      wr_done_q    <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && hit_valid_i && vic_valid_i) rr_q <= ~rr_q;
      case (state_q)
        ST_IDLE: begin
          if (grant_vic) begin
            set_q <= vic_set_i;
            map_q <= 8'h00;
            vic_q <= 1'b1;
          end else if (grant_hit) begin
            set_q <= hit_set_i;
            map_q <= hit_way_i;
            vic_q <= 1'b0;
          end
        end
        ST_RD: begin
          word_q    <= rd_word;
          wr_done_q <= 1'b0;
          if (vic_q) begin
            map_q        <= 8'b0000_0001 << rd_victim;
            resp_way_q   <= rd_victim;
            resp_valid_q <= 1'b1;
          end
        end
        ST_WR: begin
          wr_done_q <= 1'b1;
          if (vic_q && vic_resp_ready_i) resp_valid_q <= 1'b0;
        end
        default: resp_valid_q <= 1'b0;
      endcase
    end
  end

  // State-word array; written once per request on the first WR cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_SETS; i++) words_q[i] <= 7'b0;
    end else if (wr_en) begin
      words_q[set_q] <= new_word;
    end
  end

`ifdef PLRU_SET_CTRL_STATS_EN
  logic [15:0] stat_hit_q, stat_vic_q;

  // Saturating completion counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_hit_q <= 16'h0000;
      stat_vic_q <= 16'h0000;
    end else if (leave_wr) begin
      if (!vic_q && stat_hit_q != 16'hFFFF) stat_hit_q <= stat_hit_q + 16'h0001;
      if (vic_q && stat_vic_q != 16'hFFFF)  stat_vic_q <= stat_vic_q + 16'h0001;
    end
  end

  assign stat_hit_cnt_o = stat_hit_q;
  assign stat_vic_cnt_o = stat_vic_q;
`endif

endmodule

// File: tb/tb_plru_set_ctrl.sv
// Scoreboard bench for plru_set_ctrl: victim ways queued at grant, checked when the response handshakes.
module tb_plru_set_ctrl;
  localparam int NUM_SETS = 64;
  localparam int SET_W    = 6;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             hit_valid_i = 1'b0;
  logic             hit_ready_o;
  logic [SET_W-1:0] hit_set_i = '0;
  logic [7:0]       hit_way_i = 8'h00;
  logic             vic_valid_i = 1'b0;
  logic             vic_ready_o;
  logic [SET_W-1:0] vic_set_i = '0;
  logic             vic_resp_valid_o;
  logic [2:0]       vic_resp_way_o;
  logic             vic_resp_ready_i = 1'b1;
  logic             busy_o;
`ifdef PLRU_SET_CTRL_STATS_EN
  logic [15:0]      stat_hit_cnt_o, stat_vic_cnt_o;
`endif

  int         checks = 0;
  int         failures = 0;
  logic [2:0] exp_q [$];
  logic [7:0] seen_mask = 8'h00;

  plru_set_ctrl #(.NUM_SETS(NUM_SETS)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .hit_valid_i(hit_valid_i), .hit_ready_o(hit_ready_o),
    .hit_set_i(hit_set_i), .hit_way_i(hit_way_i),
    .vic_valid_i(vic_valid_i), .vic_ready_o(vic_ready_o), .vic_set_i(vic_set_i),
    .vic_resp_valid_o(vic_resp_valid_o), .vic_resp_way_o(vic_resp_way_o),
    .vic_resp_ready_i(vic_resp_ready_i), .busy_o(busy_o)
`ifdef PLRU_SET_CTRL_STATS_EN
    , .stat_hit_cnt_o(stat_hit_cnt_o), .stat_vic_cnt_o(stat_vic_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Pop the scoreboard on every completed victim handshake.
  always @(negedge clk_i) begin
    if (!rst_i && vic_resp_valid_o && vic_resp_ready_i) begin
      seen_mask = seen_mask | (8'b0000_0001 << vic_resp_way_o);
      if (exp_q.size() == 0) check_val("vic_unexpected", 32'd1, 32'd0);
      else                   check_val("vic_way", vic_resp_way_o, exp_q.pop_front());
    end
  end

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    exp_q.delete();
  endtask

  task automatic send_vic(input logic [SET_W-1:0] set, input logic [2:0] exp, input bit push);
    int n = 0;
    @(negedge clk_i);
    vic_valid_i = 1'b1;
    vic_set_i   = set;
    #1;
    while (!vic_ready_o && n < 50) begin
      @(negedge clk_i); #1; n++;
    end
    if (n >= 50) check_val("vic_grant_timeout", 32'd0, 32'd1);
    else if (push) exp_q.push_back(exp);
    @(posedge clk_i); #1;
    vic_valid_i = 1'b0;
  endtask

  task automatic send_hit(input logic [SET_W-1:0] set, input logic [7:0] map);
    int n = 0;
    @(negedge clk_i);
    hit_valid_i = 1'b1;
    hit_set_i   = set;
    hit_way_i   = map;
    #1;
    while (!hit_ready_o && n < 50) begin
      @(negedge clk_i); #1; n++;
    end
    if (n >= 50) check_val("hit_grant_timeout", 32'd0, 32'd1);
    @(posedge clk_i); #1;
    hit_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk_i);
    while ((busy_o || vic_resp_valid_o) && n < 100) begin
      @(negedge clk_i); n++;
    end
    if (n >= 100) check_val("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [2:0] seq [8];
    logic       arb_exp [4];
    int         g, viol, budget;
    bit         just_granted;
    seq = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
    arb_exp = '{1'b0, 1'b1, 1'b0, 1'b1};

    do_reset();
    #1;
    check_val("rst_busy", busy_o, 32'd0);
    check_val("rst_resp_valid", vic_resp_valid_o, 32'd0);
    check_val("rst_resp_way", vic_resp_way_o, 32'd0);
    check_val("rst_hit_ready", hit_ready_o, 32'd1);
    check_val("rst_vic_ready", vic_ready_o, 32'd1);

    // First victim on set 5: way 0 at T+2, then the word 1010001 gives way 4.
    send_vic(6'd5, 3'd0, 1'b1);
    @(negedge clk_i);
    check_val("lat_t1_valid", vic_resp_valid_o, 32'd0);
    @(negedge clk_i);
    check_val("lat_t2_valid", vic_resp_valid_o, 32'd1);
    wait_idle();
    send_vic(6'd5, 3'd4, 1'b1);
    wait_idle();

    // Eight back-to-back victims on set 3 walk every way once.
    seen_mask = 8'h00;
    for (int i = 0; i < 8; i++) send_vic(6'd3, seq[i], 1'b1);
    wait_idle();
    check_val("set3_all_ways", seen_mask, 32'hFF);

    // Hit updates: one-hot, empty map, multi-hot.
    send_hit(6'd9, 8'h01);
    send_vic(6'd9, 3'd4, 1'b1);
    send_hit(6'd12, 8'h00);
    send_vic(6'd12, 3'd0, 1'b1);
    send_hit(6'd13, 8'h11);
    send_vic(6'd13, 3'd6, 1'b1);
    wait_idle();
    check_val("sb_empty_a", exp_q.size(), 32'd0);

    // Round-robin arbitration with both requesters held valid.
    do_reset();
    @(negedge clk_i);
    hit_valid_i = 1'b1; hit_set_i = 6'd20; hit_way_i = 8'h01;
    vic_valid_i = 1'b1; vic_set_i = 6'd21;
    g = 0; viol = 0; budget = 0; just_granted = 1'b0;
    while (g < 4 && budget < 100) begin
      #1;
      if (busy_o && (hit_ready_o || vic_ready_o)) viol++;
      if (just_granted) check_val("arb_busy_after_grant", busy_o, 32'd1);
      just_granted = 1'b0;
      if (hit_valid_i && hit_ready_o) begin
        check_val("arb_order", 32'd0, arb_exp[g]);
        g++; just_granted = 1'b1;
      end else if (vic_valid_i && vic_ready_o) begin
        check_val("arb_order", 32'd1, arb_exp[g]);
        exp_q.push_back((g == 1) ? 3'd0 : 3'd4);
        g++; just_granted = 1'b1;
      end
      if (g == 4) begin
        @(posedge clk_i); #1;
        hit_valid_i = 1'b0; vic_valid_i = 1'b0;
      end else begin
        @(negedge clk_i);
      end
      budget++;
    end
    check_val("arb_grants", g, 32'd4);
    check_val("arb_ready_outside_idle", viol, 32'd0);
    wait_idle();
    check_val("sb_empty_b", exp_q.size(), 32'd0);

    // Held response, then reset in the middle of the hold.
    vic_resp_ready_i = 1'b0;
    send_vic(6'd22, 3'd0, 1'b0);
    budget = 0;
    while (!vic_resp_valid_o && budget < 20) begin
      @(negedge clk_i); budget++;
    end
    check_val("hold_rise", vic_resp_valid_o, 32'd1);
    hit_valid_i = 1'b1; hit_set_i = 6'd23; hit_way_i = 8'h02;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i); #1;
      check_val("hold_valid", vic_resp_valid_o, 32'd1);
      check_val("hold_way", vic_resp_way_o, 32'd0);
      check_val("hold_no_grant", hit_ready_o, 32'd0);
    end
    #2 rst_i = 1'b1;
    #1;
    check_val("mid_rst_valid", vic_resp_valid_o, 32'd0);
    check_val("mid_rst_busy", busy_o, 32'd0);
    hit_valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    vic_resp_ready_i = 1'b1;
    send_vic(6'd22, 3'd0, 1'b1);
    send_vic(6'd21, 3'd0, 1'b1);
    send_vic(6'd20, 3'd0, 1'b1);
    send_vic(6'd5, 3'd0, 1'b1);
    wait_idle();
    check_val("sb_empty_c", exp_q.size(), 32'd0);

`ifdef PLRU_SET_CTRL_STATS_EN
    do_reset();
    send_hit(6'd30, 8'h01);
    send_hit(6'd31, 8'h02);
    send_hit(6'd32, 8'h04);
    send_vic(6'd33, 3'd0, 1'b1);
    send_vic(6'd33, 3'd4, 1'b1);
    wait_idle();
    check_val("stat_hit", stat_hit_cnt_o, 32'd3);
    check_val("stat_vic", stat_vic_cnt_o, 32'd2);
    @(negedge clk_i);
    force dut.stat_hit_q = 16'hFFFF;
    @(negedge clk_i);
    release dut.stat_hit_q;
    send_hit(6'd34, 8'h01);
    wait_idle();
    check_val("stat_hit_sat", stat_hit_cnt_o, 32'hFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/plru_set_ctrl.md
Name: plru_set_ctrl

Overview:
- Per-set replacement controller for an 8-way set-associative cache.
- Holds one 7-bit tree-PLRU state word per set and applies hit updates from the lookup pipe.
- Serves victim-way requests from the miss/refill path, with round-robin arbitration between the two requesters.
- Serialises all accesses through a 3-state FSM, so same-set read-modify-write hazards cannot occur.

Parameters:
- NUM_SETS, 64, number of sets; power of two, at least 2. Local SET_W = $clog2(NUM_SETS).

Ports:
- clk_i  input  1  clock
- rst_i  input  1  asynchronous reset, active-high
- hit_valid_i  input  1  hit-update request
- hit_ready_o  output  1  hit request accepted this cycle when valid&ready
- hit_set_i  input  SET_W  set index of the hit
- hit_way_i  input  8  access map of ways touched (normally one-hot)
- vic_valid_i  input  1  victim request
- vic_ready_o  output  1  victim request accepted when valid&ready
- vic_set_i  input  SET_W  set needing a victim
- vic_resp_valid_o  output  1  victim result valid
- vic_resp_way_o  output  3  victim way index
- vic_resp_ready_i  input  1  consumer accepts result
- busy_o  output  1  FSM not in IDLE

Behaviour:
- State word per set, bits n6..n0, held in flops.
- Tree layout:
  - n6 compares ways 7:4 against 3:0.
  - n5 compares 7:6 against 5:4; n4 compares 3:2 against 1:0.
  - n3 compares 7 against 6; n2 compares 5 against 4; n1 compares 3 against 2; n0 compares 1 against 0.
- Bit meaning: 0 means the lower-index side is LRU; 1 means the upper-index side is LRU.
- Update rule for an access map M: each node flips iff M has any bit set within that node's LRU side; otherwise it holds. All 7 nodes are evaluated from the old word simultaneously.
- Victim: v = n6 ? (n5 ? (n3?7:6) : (n2?5:4)) : (n4 ? (n1?3:2) : (n0?1:0)).
- A victim allocation is itself an access: the word is updated with M = onehot(v).
- FSM states: IDLE, RD, WR.
  - IDLE: grants one requester. Latches the set index, map and type (hit/victim), then moves to RD.
  - RD: registers the addressed state word; moves to WR.
  - WR: computes the new word and writes it to the array.
    - Hit type: returns to IDLE in the same cycle.
    - Victim type: asserts vic_resp_valid_o with vic_resp_way_o = v. Stays in WR, with no further writes, until vic_resp_ready_i; then returns to IDLE.
- Latency: a request accepted at cycle T has its updated word visible to a request read at T+2 or later. vic_resp_valid_o rises at T+2 at the earliest.
- Handshake and arbitration:
  - hit_ready_o = IDLE & (!vic_valid_i | rr_ptr==HIT).
  - vic_ready_o = IDLE & (!hit_valid_i | rr_ptr==VIC).
  - rr_ptr flips to the other requester after every grant made while both requesters were valid.
  - Each ready is independent of its own valid; at most one grant per cycle.
- vic_resp_way_o and vic_resp_valid_o hold stable while valid & !ready.
- hit_way_i = 0: the request is accepted, the word is rewritten unchanged, and there is no side effect.
- Multi-hot hit_way_i: the update rule above applies unchanged.
- Reset (any time, including mid-operation):
  - All state words clear to 0; FSM goes to IDLE; rr_ptr = HIT.
  - vic_resp_valid_o = 0, vic_resp_way_o = 0, busy_o = 0.
  - Any in-flight request is dropped.
- After reset every set's victim is way 0.

Optional Feature:
- Macro PLRU_SET_CTRL_STATS_EN.
- Defined:
  - Adds outputs stat_hit_cnt_o[15:0] and stat_vic_cnt_o[15:0].
  - Each counter increments on completion (FSM leaving WR) of a hit or victim request respectively.
  - Counters saturate at 16'hFFFF and clear on reset.
- Undefined: neither the ports nor the counters exist, and there is no other behavioural difference.

Test Plan:
- Reset, then a victim request on set 5 with ready held high -> way 0 at T+2; set 5 word = 7'b1010001 (n6, n4, n0 set).
- From reset, victim requests on set 3 issued 8 times back-to-back -> ways 0,4,2,6,1,5,3,7 in order. Every way is returned exactly once.
- Hit on set 9 with way 0 (map 8'h01) from the reset word -> word becomes 7'b1010001; a following victim on set 9 returns way 4.
- hit_valid_i and vic_valid_i held together for 4 grants, from reset (rr_ptr=HIT) -> grant order HIT, VIC, HIT, VIC. busy_o is high between grants, and ready is never asserted outside IDLE.
- Victim response held for 5 cycles with vic_resp_ready_i=0 -> valid and way stable throughout and no new grant. Asserting rst_i mid-hold -> response valid drops immediately and all words read back as 0.
- STATS_EN build: 3 hits plus 2 victims -> stat_hit_cnt_o=3, stat_vic_cnt_o=2. Counter forced to 16'hFFFF followed by one more hit -> it stays 16'hFFFF.
